// File: rtl/nrzi_decoder_if.sv
// ---------------------------------------------------------------------------
// nrzi_decoder_if
// Groups the serial line input, the received-byte valid/ready handshake and
// the status pulses of the NRZI receiver into one bundle.
//
// Signals
//   bit_en_i    : bit strobe, line is sampled only when 1
//   nrzi_i      : NRZI line level
//   ready_i     : downstream accepts data_o when valid_o && ready_i
//   data_o[7:0] : received byte, LSB = first bit on the line
//   valid_o     : data_o holds an unconsumed byte
//   frame_end_o : pulse on the closing flag of a frame that delivered bytes
//   frame_err_o : pulse on a flag that arrives off a byte boundary
//   abort_o     : pulse on an abort sequence
//   overrun_o   : pulse when a completed byte had to be dropped
//   hunt_o      : 1 while searching for an opening flag
//
// Modports
//   master : the decoder side (drives the byte stream and status)
//   slave  : the line driver / byte consumer side
// ---------------------------------------------------------------------------
interface nrzi_decoder_if;
    logic       bit_en_i;
    logic       nrzi_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_end_o;
    logic       frame_err_o;
    logic       abort_o;
    logic       overrun_o;
    logic       hunt_o;

    modport master (
        input  bit_en_i, nrzi_i, ready_i,
        output data_o, valid_o, frame_end_o, frame_err_o, abort_o, overrun_o, hunt_o
    );

    modport slave (
        output bit_en_i, nrzi_i, ready_i,
        input  data_o, valid_o, frame_end_o, frame_err_o, abort_o, overrun_o, hunt_o
    );
endinterface

// File: rtl/nrzi_decoder.sv
// ---------------------------------------------------------------------------
// nrzi_decoder
// Receive side of an NRZI/HDLC-style serial link. A transition on the line
// decodes to 1, no transition to 0. Stuffed zeros are removed, 0x7E flags
// delimit frames, and data is assembled LSB-first into bytes that are
// delivered over a valid/ready handshake.
//
// Parameters
//   IDLE_LEVEL : line level assumed before the first sample
//   STUFF_RUN  : number of consecutive 1s after which a 0 is a stuffed bit
//
// Ports
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : nrzi_decoder_if.master (line input, byte handshake, status)
//
// Build option
//   NRZI_DEC_ABORT_EN : when defined, seven consecutive 1s inside a frame
//   pulse abort_o and return the receiver to HUNT. When undefined abort_o
//   is tied low and long runs of 1s are ordinary data.
// ---------------------------------------------------------------------------
module nrzi_decoder #(
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   STUFF_RUN  = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    nrzi_decoder_if.master bus
);

    localparam logic [2:0] LP_STUFF = 3'(STUFF_RUN);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RX   = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_prev;
    logic [7:0] r_window;
    logic [2:0] r_ones;
    logic [2:0] r_cnt;
    logic       r_byte_seen;
    logic [7:0] r_asm;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_end;
    logic       r_frame_err;
    logic       r_abort;
    logic       r_overrun;

    logic       w_d;
    logic [7:0] w_window;
    logic       w_flag;
    logic       w_drop;
    logic       w_abort_hit;
    logic [2:0] w_ones_nxt;
    logic [2:0] w_cnt_nxt;
    logic [7:0] w_asm_nxt;
    logic       w_seen_nxt;
    logic       w_byte_done;
    logic       w_frame_end;
    logic       w_frame_err;
    logic       w_abort;
    logic       w_load;
    logic       w_overrun;
    logic       w_valid_nxt;

    assign w_d      = bus.nrzi_i ^ r_prev;
    // Newest decoded bit enters at the top so the window reads LSB-first.
    assign w_window = {w_d, r_window[7:1]};
    assign w_flag   = (w_window == 8'h7E);
    // The ones count is the run *before* this bit, so a 0 directly after
    // exactly STUFF_RUN ones is the stuffed bit.
    assign w_drop   = (r_ones == LP_STUFF) && !w_d;

    always_comb begin
        w_ones_nxt = 3'd0;
        if (w_d) begin
            w_ones_nxt = (r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1;
        end
    end

`ifdef NRZI_DEC_ABORT_EN
    // Fires once per run: the counter saturates at 7 and never passes 6 again.
    assign w_abort_hit = w_d && (r_ones == 3'd6);
`else
    assign w_abort_hit = 1'b0;
`endif

    // Next-state / framing decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_asm_nxt   = r_asm;
        w_seen_nxt  = r_byte_seen;
        w_byte_done = 1'b0;
        w_frame_end = 1'b0;
        w_frame_err = 1'b0;
        w_abort     = 1'b0;

        if (bus.bit_en_i) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_flag) begin
                        w_state_nxt = ST_RX;
                        w_cnt_nxt   = 3'd0;
                        w_seen_nxt  = 1'b0;
                    end
                end
                ST_RX: begin
                    if (w_abort_hit) begin
                        w_abort     = 1'b1;
                        w_state_nxt = ST_HUNT;
                        w_cnt_nxt   = 3'd0;
                    end else if (w_flag) begin
                        // A flag landing exactly on the 8th bit closes the frame;
                        // the "byte" it would complete is the flag itself.
                        if (!w_drop && (r_cnt == 3'd7)) begin
                            w_frame_end = r_byte_seen;
                        end else begin
                            w_frame_err = 1'b1;
                        end
                        w_cnt_nxt  = 3'd0;
                        w_seen_nxt = 1'b0;
                    end else if (!w_drop) begin
                        w_asm_nxt   = {w_d, r_asm[7:1]};
                        // 3-bit count wraps 7 -> 0 exactly on byte completion.
                        w_cnt_nxt   = r_cnt + 3'd1;
                        w_byte_done = (r_cnt == 3'd7);
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end

        // A slot is free if empty or being emptied on this same edge.
        w_load    = w_byte_done && (!r_valid || bus.ready_i);
        w_overrun = w_byte_done && !w_load;
        if (w_load) begin
            w_seen_nxt = 1'b1;
        end

        w_valid_nxt = r_valid;
        if (w_load) begin
            w_valid_nxt = 1'b1;
        end else if (r_valid && bus.ready_i) begin
            w_valid_nxt = 1'b0;
        end
    end

    // Registered state, line history and output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_HUNT;
            r_prev      <= IDLE_LEVEL;
            r_window    <= 8'h00;
            r_ones      <= 3'd0;
            r_cnt       <= 3'd0;
            r_byte_seen <= 1'b0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_frame_err <= 1'b0;
            r_abort     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_byte_seen <= w_seen_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_end <= w_frame_end;
            r_frame_err <= w_frame_err;
            r_abort     <= w_abort;
            r_overrun   <= w_overrun;
            if (bus.bit_en_i) begin
                r_prev   <= bus.nrzi_i;
                r_window <= w_window;
                r_ones   <= w_ones_nxt;
            end
            if (w_load) begin
                r_data <= w_asm_nxt;
            end
        end
    end

    // Assembler contents are meaningless until 8 bits are counted in, so it
    // carries no reset.
    always_ff @(posedge clk_i) begin
        r_asm <= w_asm_nxt;
    end

    assign bus.data_o      = r_data;
    assign bus.valid_o     = r_valid;
    assign bus.frame_end_o = r_frame_end;
    assign bus.frame_err_o = r_frame_err;
    assign bus.abort_o     = r_abort;
    assign bus.overrun_o   = r_overrun;
    assign bus.hunt_o      = (r_state == ST_HUNT);

endmodule

// File: tb/tb_nrzi_decoder.sv
// ---------------------------------------------------------------------------
// tb_nrzi_decoder
// Scoreboard bench for nrzi_decoder. A reference model (bit history and
// partial-byte queues) runs on every clock edge and pushes the expected
// status of the following cycle plus every byte it expects to be loaded.
// A monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_nrzi_decoder;
    localparam int   STUFF_RUN  = 5;
    localparam logic IDLE_LEVEL = 1'b0;
`ifdef NRZI_DEC_ABORT_EN
    localparam bit   ABORT_EN   = 1'b1;
`else
    localparam bit   ABORT_EN   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    nrzi_decoder_if bus ();

    nrzi_decoder #(
        .IDLE_LEVEL(IDLE_LEVEL),
        .STUFF_RUN (STUFF_RUN)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pls;   // {overrun, abort, frame_err, frame_end}
        logic       vld;
        logic       hnt;
    } rec_t;

    int checks = 0;
    int errors = 0;

    rec_t       sb[$];
    logic [7:0] bq[$];

    // reference model state
    logic m_prev;
    bit   m_hist[$];
    int   m_run;
    bit   m_hunt;
    bit   m_part[$];
    bit   m_seen;
    bit   m_valid;

    // observation counters
    int         cnt_fe = 0, cnt_err = 0, cnt_abt = 0, cnt_ovr = 0, cnt_bytes = 0;
    logic [7:0] last_byte = 8'h00;

    // stimulus state
    logic line       = IDLE_LEVEL;
    int   ready_mode = 1;
    bit   gaps       = 1'b0;
    int   tx_ones    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rec_t r;
        m_prev = IDLE_LEVEL;
        m_hist.delete();
        repeat (8) m_hist.push_back(1'b0);
        m_run   = 0;
        m_hunt  = 1'b1;
        m_part.delete();
        m_seen  = 1'b0;
        m_valid = 1'b0;
        sb.delete();
        bq.delete();
        r.pls = 4'b0;
        r.vld = 1'b0;
        r.hnt = 1'b1;
        sb.push_back(r);
    endtask

    task automatic model_step();
        rec_t       r;
        bit         d, flag, drop, done;
        logic [7:0] w, byte_v;
        int         run_b;
        r.pls  = 4'b0;
        done   = 1'b0;
        byte_v = 8'h00;
        if (bus.bit_en_i) begin
            d      = bus.nrzi_i ^ m_prev;
            m_prev = bus.nrzi_i;
            run_b  = (m_run > 7) ? 7 : m_run;
            m_hist.push_back(d);
            void'(m_hist.pop_front());
            w = 8'h00;
            for (int i = 0; i < 8; i++) w[i] = m_hist[i];
            flag  = (w == 8'h7E);
            drop  = (run_b == STUFF_RUN) && !d;
            m_run = d ? m_run + 1 : 0;
            if (m_hunt) begin
                if (flag) begin
                    m_hunt = 1'b0;
                    m_part.delete();
                    m_seen = 1'b0;
                end
            end else if (ABORT_EN && d && run_b == 6) begin
                r.pls[2] = 1'b1;
                m_hunt   = 1'b1;
                m_part.delete();
            end else if (flag) begin
                if (!drop && m_part.size() == 7) r.pls[0] = m_seen;
                else r.pls[1] = 1'b1;
                m_part.delete();
                m_seen = 1'b0;
            end else if (!drop) begin
                m_part.push_back(d);
                if (m_part.size() == 8) begin
                    for (int i = 0; i < 8; i++) byte_v[i] = m_part[i];
                    m_part.delete();
                    done = 1'b1;
                end
            end
        end
        if (done) begin
            if (!m_valid || bus.ready_i) begin
                bq.push_back(byte_v);
                m_valid = 1'b1;
                m_seen  = 1'b1;
            end else begin
                r.pls[3] = 1'b1;
            end
        end else if (m_valid && bus.ready_i) begin
            m_valid = 1'b0;
        end
        r.vld = m_valid;
        r.hnt = m_hunt;
        sb.push_back(r);
    endtask

    // reference model
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual=0 required=1 t=%0t", $time);
            end else begin
                rec_t e;
                e = sb.pop_front();
                chk("pulses", {bus.overrun_o, bus.abort_o, bus.frame_err_o, bus.frame_end_o}, e.pls);
                chk("valid", bus.valid_o, e.vld);
                chk("hunt", bus.hunt_o, e.hnt);
            end
            if (!rst && bus.valid_o && bus.ready_i) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_unexpected actual=%0h required=none t=%0t", bus.data_o, $time);
                end else begin
                    chk("byte", bus.data_o, bq.pop_front());
                end
                cnt_bytes++;
                last_byte = bus.data_o;
            end
            if (bus.frame_end_o) cnt_fe++;
            if (bus.frame_err_o) cnt_err++;
            if (bus.abort_o)     cnt_abt++;
            if (bus.overrun_o)   cnt_ovr++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc_drive(input logic en, input logic lvl);
        bus.bit_en_i = en;
        bus.nrzi_i   = lvl;
        case (ready_mode)
            0:       bus.ready_i = 1'b0;
            1:       bus.ready_i = 1'b1;
            default: bus.ready_i = ($urandom_range(0, 3) != 0);
        endcase
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, line);
    endtask

    task automatic send_bit(input bit b);
        if (gaps) repeat ($urandom_range(0, 2)) cyc_drive(1'b0, line);
        line = line ^ b;
        cyc_drive(1'b1, line);
    endtask

    task automatic send_flag();
        logic [7:0] v;
        v = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        tx_ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
            if (v[i]) begin
                tx_ones++;
                if (tx_ones == STUFF_RUN) begin
                    send_bit(1'b0);
                    tx_ones = 0;
                end
            end else begin
                tx_ones = 0;
            end
        end
    endtask

    int         fe0, err0, abt0, ovr0, by0, nb, sel;
    logic [7:0] v5a;

    initial begin
        bus.bit_en_i = 1'b0;
        bus.nrzi_i   = IDLE_LEVEL;
        bus.ready_i  = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_data", bus.data_o, 8'h00);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_hunt", bus.hunt_o, 1);
        idle(2);

        // single byte
        fe0 = cnt_fe; by0 = cnt_bytes;
        send_flag();
        chk("hunt_after_flag", bus.hunt_o, 0);
        send_byte(8'hA5);
        send_flag();
        idle(3);
        chk("single_bytes", cnt_bytes - by0, 1);
        chk("single_data", last_byte, 8'hA5);
        chk("single_fe", cnt_fe - fe0, 1);

        // destuffing
        fe0 = cnt_fe; err0 = cnt_err;
        send_flag();
        send_byte(8'hFF);
        send_flag();
        idle(3);
        chk("stuff_data", last_byte, 8'hFF);
        chk("stuff_err", cnt_err - err0, 0);
        chk("stuff_fe", cnt_fe - fe0, 1);

        // back-pressure
        ready_mode = 0;
        ovr0 = cnt_ovr;
        send_flag();
        send_byte(8'h11);
        send_byte(8'h22);
        send_flag();
        idle(3);
        chk("bp_data", bus.data_o, 8'h11);
        chk("bp_valid", bus.valid_o, 1);
        chk("bp_overrun", cnt_ovr - ovr0, 1);
        ready_mode = 1;
        idle(2);
        chk("bp_release", bus.valid_o, 0);
        chk("bp_delivered", last_byte, 8'h11);

        // misaligned flag
        fe0 = cnt_fe; err0 = cnt_err;
        send_flag();
        repeat (3) send_bit(1'b0);
        send_flag();
        idle(3);
        chk("mis_err", cnt_err - err0, 1);
        chk("mis_fe", cnt_fe - fe0, 0);

        // abort sequence
        abt0 = cnt_abt;
        send_flag();
        send_byte(8'h0F);
        repeat (8) send_bit(1'b1);
        idle(3);
        chk("abort_count", cnt_abt - abt0, ABORT_EN ? 1 : 0);
        chk("abort_hunt", bus.hunt_o, ABORT_EN ? 1 : 0);
        chk("abort_data", last_byte, ABORT_EN ? 8'h0F : 8'hFF);

        // reset in the middle of a byte
        send_flag();
        v5a = 8'h5A;
        for (int i = 0; i < 4; i++) send_bit(v5a[i]);
        bus.bit_en_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_data", bus.data_o, 8'h00);
        chk("rstmid_valid", bus.valid_o, 0);
        chk("rstmid_hunt", bus.hunt_o, 1);
        chk("rstmid_pulses", {bus.overrun_o, bus.abort_o, bus.frame_err_o, bus.frame_end_o}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        line = IDLE_LEVEL;
        fe0 = cnt_fe;
        idle(2);
        send_flag();
        chk("rstmid_rx", bus.hunt_o, 0);
        send_byte(8'h5A);
        send_flag();
        idle(3);
        chk("rstmid_byte", last_byte, 8'h5A);
        chk("rstmid_fe", cnt_fe - fe0, 1);

        // randomized frames with gaps, random ready and line faults
        gaps = 1'b1;
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 4);
            send_flag();
            for (int b = 0; b < nb; b++) send_byte(8'($urandom_range(0, 255)));
            sel = $urandom_range(0, 5);
            if (sel == 0) begin
                repeat ($urandom_range(1, 6)) send_bit(1'($urandom_range(0, 1)));
            end else if (sel == 1) begin
                repeat (7) send_bit(1'b1);
            end
        end
        send_flag();
        gaps = 1'b0;
        ready_mode = 1;
        idle(12);
        chk("drain", bq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
